fmc_periph_tester: RTL and testbench

FMC_PERIPH_TESTER -- requirements
Module: fmc_periph_tester

---
 rtl/fmc_periph_tester.sv | 184 ++++++++++++++++++
 tb/tb_fmc_periph_tester.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fmc_periph_tester.sv
// FMC peripheral tester: synchronised keys/switches/usb, debounced mode key,
// LED pattern modes. Optional chaser mode via FMC_PERIPH_TESTER_CHASER_EN.
module fmc_periph_tester #(
  parameter int KEY_N      = 4,
  parameter int SW_N       = 4,
  parameter int LED_W      = 8,
  parameter int CNT_W      = 32,
  parameter int GPIO_W     = 16,
  parameter int DEB_CYCLES = 65536,
  parameter int CHASE_SH   = 20
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [KEY_N-1:0]  key_i,
  input  logic [SW_N-1:0]   switch_i,
  input  logic              usb_det_i,
  output logic [LED_W-1:0]  led_o,
  output logic [GPIO_W-1:0] gpio_o,
  output logic [2:0]        mode_o,
  output logic [KEY_N-1:0]  key_db_o
);

  localparam int DW = $clog2(DEB_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

`ifdef FMC_PERIPH_TESTER_CHASER_EN
  localparam logic [2:0] MODE_MAX = 3'd4;
`else
  localparam logic [2:0] MODE_MAX = 3'd3;
`endif

  typedef enum logic [2:0] {
    M_USB   = 3'd0,
    M_CAT   = 3'd1,
    M_XOR   = 3'd2,
    M_CNT   = 3'd3,
    M_CHASE = 3'd4
  } mode_e;

  logic [KEY_N-1:0]         key_s1_q, key_s2_q;
  logic [SW_N-1:0]          sw_s1_q, sw_s2_q;
  logic                     usb_s1_q, usb_s2_q;
  logic [KEY_N-1:0][DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [KEY_N-1:0]         key_db_q, key_db_d;
  mode_e                    mode_q, mode_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [LED_W-1:0]         led_q, led_d;
  logic                     adv;

  logic [LED_W-1:0]         pat_usb;
  logic [LED_W-1:0]         pat_cat;
  logic [LED_W-1:0]         pat_xor;
  logic [LED_W-1:0]         pat_cnt;
  logic [SW_N-1:0]          mix;
  logic [SW_N+KEY_N+LED_W-1:0] cat_x;
  logic [SW_N+KEY_N-1:0]       db_x;

  // A level is accepted only after DEB_CYCLES consecutive differing samples
  always_comb begin
    deb_cnt_d = '0;
    key_db_d  = key_db_q;
    for (int k = 0; k < KEY_N; k++) begin
      if (key_s2_q[k] != key_db_q[k]) begin
        if (deb_cnt_q[k] == DEB_LAST) begin
          key_db_d[k] = key_s2_q[k];
        end else begin
          deb_cnt_d[k] = deb_cnt_q[k] + 1'b1;
        end
      end
    end
  end

  assign adv = key_db_q[1] & ~key_db_d[1];

  always_comb begin
    mode_d = mode_q;
    if (adv) begin
      if (mode_q == mode_e'(MODE_MAX)) begin
        mode_d = M_USB;
      end else begin
        mode_d = mode_e'(mode_q + 3'd1);
      end
    end
  end

  assign cnt_d = cnt_q + 1'b1;

`ifdef FMC_PERIPH_TESTER_CHASER_EN
  logic [LED_W-1:0] chaser_q, chaser_d;
  logic             chase_step;

  assign chase_step = &cnt_q[CHASE_SH-1:0];

  always_comb begin
    chaser_d = chaser_q;
    if (chase_step) begin
      for (int i = 0; i < LED_W; i++) begin
        chaser_d[i] = chaser_q[(i + LED_W - 1) % LED_W];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      chaser_q <= LED_W'(1);
    end else begin
      chaser_q <= chaser_d;
    end
  end
`endif

  always_comb begin
    pat_usb    = {LED_W{usb_s2_q}};
    pat_usb[0] = ~usb_s2_q;
  end

  assign cat_x   = {{LED_W{1'b0}}, sw_s2_q, key_db_q};
  assign pat_cat = cat_x[LED_W-1:0];
  assign db_x    = {{SW_N{1'b0}}, key_db_q};
  assign mix     = sw_s2_q ^ db_x[SW_N-1:0];

  always_comb begin
    pat_xor = '0;
    for (int i = 0; i < LED_W; i++) begin
      pat_xor[i] = mix[i % SW_N];
    end
  end

  generate
    if (CNT_W >= LED_W) begin : g_cnt_top
      assign pat_cnt = cnt_q[CNT_W-1 -: LED_W];
    end else begin : g_cnt_ext
      assign pat_cnt = {{(LED_W-CNT_W){1'b0}}, cnt_q};
    end
  endgenerate

  always_comb begin
    led_d = '0;
    case (mode_q)
      M_USB:   led_d = pat_usb;
      M_CAT:   led_d = pat_cat;
      M_XOR:   led_d = pat_xor;
      M_CNT:   led_d = pat_cnt;
`ifdef FMC_PERIPH_TESTER_CHASER_EN
      M_CHASE: led_d = chaser_q;
`endif
      default: led_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      key_s1_q  <= '1;
      key_s2_q  <= '1;
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      usb_s1_q  <= 1'b0;
      usb_s2_q  <= 1'b0;
      deb_cnt_q <= '0;
      key_db_q  <= '1;
      mode_q    <= M_USB;
      cnt_q     <= '0;
      led_q     <= LED_W'(1);
    end else begin
      key_s1_q  <= key_i;
      key_s2_q  <= key_s1_q;
      sw_s1_q   <= switch_i;
      sw_s2_q   <= sw_s1_q;
      usb_s1_q  <= usb_det_i;
      usb_s2_q  <= usb_s1_q;
      deb_cnt_q <= deb_cnt_d;
      key_db_q  <= key_db_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      led_q     <= led_d;
    end
  end

  assign led_o    = led_q;
  assign gpio_o   = cnt_q[CNT_W-1 -: GPIO_W];
  assign mode_o   = mode_q;
  assign key_db_o = key_db_q;

endmodule

// File: tb/tb_fmc_periph_tester.sv
// Scoreboard bench for fmc_periph_tester with a behavioural reference model.
module tb_fmc_periph_tester;

  localparam int KEY_N = 4;
  localparam int SW_N  = 4;
  localparam int LED_W = 8;
  localparam int CNT_W = 8;
  localparam int GPIO_W = 4;
  localparam int DEB  = 4;
  localparam int CSH  = 2;

`ifdef FMC_PERIPH_TESTER_CHASER_EN
  localparam int MMAX = 4;
`else
  localparam int MMAX = 3;
`endif

  typedef struct {
    logic [7:0] led;
    logic [3:0] gpio;
    logic [2:0] mode;
    logic [3:0] db;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] key_i;
  logic [3:0] switch_i;
  logic usb_det_i;
  logic [7:0] led_o;
  logic [3:0] gpio_o;
  logic [2:0] mode_o;
  logic [3:0] key_db_o;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  logic [3:0] keyq[$];
  logic [3:0] swq[$];
  logic       usbq[$];
  logic [3:0] db_m;
  int run_m[4];
  int mode_m;
  int n_m;
  bit rand_en;
  int hold;

  fmc_periph_tester #(
    .KEY_N(KEY_N), .SW_N(SW_N), .LED_W(LED_W), .CNT_W(CNT_W),
    .GPIO_W(GPIO_W), .DEB_CYCLES(DEB), .CHASE_SH(CSH)
  ) dut (
    .clk_i(clk), .rst_i(rst), .key_i(key_i), .switch_i(switch_i),
    .usb_det_i(usb_det_i), .led_o(led_o), .gpio_o(gpio_o),
    .mode_o(mode_o), .key_db_o(key_db_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, got, want, $time);
    end
  endtask

  function automatic exp_t reset_exp();
    exp_t e;
    e.led = 8'h01;
    e.gpio = 4'h0;
    e.mode = 3'd0;
    e.db = 4'hF;
    return e;
  endfunction

  task automatic model_reset();
    keyq = '{4'hF, 4'hF};
    swq = '{4'h0, 4'h0};
    usbq = '{1'b0, 1'b0};
    db_m = 4'hF;
    for (int k = 0; k < 4; k++) run_m[k] = 0;
    mode_m = 0;
    n_m = 0;
  endtask

  // Reference: sync = raw two edges back; counter = edges since reset;
  // chaser bit index = (edges/4) mod 8.
  task automatic model_edge();
    logic [3:0] ps, sw, x, nd;
    logic u;
    logic [7:0] led, ch;
    exp_t e;
    ps = keyq[0];
    sw = swq[0];
    u = usbq[0];
    ch = 8'(1 << ((n_m / 4) % 8));
    x = sw ^ db_m;
    case (mode_m)
      0: led = u ? 8'hFE : 8'h01;
      1: led = {sw, db_m};
      2: led = {x, x};
      3: led = 8'(n_m % 256);
      4: led = ch;
      default: led = 8'h00;
    endcase
    nd = db_m;
    for (int k = 0; k < 4; k++) begin
      if (ps[k] != db_m[k]) begin
        run_m[k]++;
        if (run_m[k] == DEB) begin
          nd[k] = ps[k];
          run_m[k] = 0;
        end
      end else begin
        run_m[k] = 0;
      end
    end
    if (db_m[1] && !nd[1]) mode_m = (mode_m == MMAX) ? 0 : mode_m + 1;
    db_m = nd;
    void'(keyq.pop_front());
    keyq.push_back(key_i);
    void'(swq.pop_front());
    swq.push_back(switch_i);
    void'(usbq.pop_front());
    usbq.push_back(usb_det_i);
    n_m++;
    e.led = led;
    e.gpio = 4'((n_m % 256) / 16);
    e.mode = 3'(mode_m);
    e.db = db_m;
    exp_q.push_back(e);
  endtask

  task automatic randomize_inputs();
    logic [3:0] k;
    k = key_i;
    if (hold == 0) begin
      k[1] = ~k[1];
      hold = $urandom_range(1, 9);
    end
    hold--;
    if ($urandom_range(0, 15) == 0) k[0] = ~k[0];
    if ($urandom_range(0, 15) == 0) k[2] = ~k[2];
    if ($urandom_range(0, 15) == 0) k[3] = ~k[3];
    key_i = k;
    if ($urandom_range(0, 31) == 0) switch_i = 4'($urandom);
    if ($urandom_range(0, 31) == 0) usb_det_i = ~usb_det_i;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) exp_q.push_back(reset_exp());
    else model_edge();
    #1;
    if (rand_en) randomize_inputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_led", led_o, 8'h01);
    check("rst_gpio", gpio_o, 0);
    check("rst_mode", mode_o, 0);
    check("rst_db", key_db_o, 4'hF);
    model_reset();
    step();
    step();
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("led", led_o, e.led);
      check("gpio", gpio_o, e.gpio);
      check("mode", mode_o, e.mode);
      check("key_db", key_db_o, e.db);
    end
  end

  initial begin
    rst = 1'b1;
    key_i = 4'hF;
    switch_i = 4'h0;
    usb_det_i = 1'b0;
    rand_en = 1'b0;
    hold = 0;
    model_reset();
    #1;
    check("init_led", led_o, 8'h01);
    check("init_mode", mode_o, 0);
    step();
    step();
    @(negedge clk);
    #1 rst = 1'b0;

    // Short press that must be rejected, then a full press
    key_i = 4'b1101;
    repeat (3) step();
    key_i = 4'hF;
    repeat (8) step();
    key_i = 4'b1101;
    repeat (10) step();
    key_i = 4'hF;
    repeat (10) step();

    // Static LED patterns across clean mode presses
    switch_i = 4'b1010;
    usb_det_i = 1'b1;
    repeat (MMAX + 2) begin
      key_i = 4'b1101;
      repeat (8) step();
      key_i = 4'hF;
      repeat (20) step();
    end
    usb_det_i = 1'b0;

    // Long run in one mode to cover counter/chaser wrap
    repeat (300) step();

    rand_en = 1'b1;
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(200, 500)) step();
      do_reset();
    end
    repeat (300) step();
    rand_en = 1'b0;

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
